wb_serial_adder_slave: RTL and testbench
========================================

Name: wb_serial_adder_slave

Overview:
Wishbone B4 classic slave that lets the management SoC drive the user-area adder datapath. The SoC is the bus initiator and this block is the responder. It holds operand registers A and B, runs a bit-serial add over BITS cycles, and exposes result, carry-out, status and an interrupt. It connects to the user_project_wrapper Wishbone slave port and to one irq line.

Parameters:
BITS, 32, operand/result width (1..32); unused upper register bits read 0
BASE_ADDR, 32'h3000_0000, base of the register window
ADDR_MASK, 32'hFFFF_FFE0, window match mask (32-byte window)

Ports:
wb_clk_i  input  1  single clock for all state
wb_rst_ni  input  1  asynchronous active-low reset
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  1 = write, 0 = read
wbs_sel_i  input  4  byte enables
wbs_dat_i  input  32  write data
wbs_adr_i  input  32  byte address
wbs_ack_o  output  1  transfer acknowledge
wbs_dat_o  output  32  read data
irq_o  output  1  done interrupt, level
busy_o  output  1  add in progress (for LA probing)

Behaviour:
- Interface: one clock, wb_clk_i; reset wb_rst_ni, asynchronous assert, active-low. All flops clear immediately when wb_rst_ni=0.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, busy_o=0. OPA, OPB, CTRL, RESULT and STATUS all clear to 0. FSM goes to IDLE.
- Address decode: a request is selected when (wbs_adr_i & ADDR_MASK)==BASE_ADDR. Offset is wbs_adr_i[4:2].
- Register map:
  - 0x00 OPA, RW.
  - 0x04 OPB, RW.
  - 0x08 CTRL: bit0 START (write-1 pulse, reads 0), bit1 CIN, bit2 IRQ_EN.
  - 0x0C STATUS: bit0 BUSY (RO), bit1 DONE (write-1-to-clear), bit2 COUT (RO).
  - 0x10 RESULT, RO.
  - Offsets 0x14..0x1C read 0; writes to them are ignored.
- Handshake:
  - When stb&cyc&selected and ack is low, wbs_ack_o is registered high for exactly one cycle. Latency is 1 cycle.
  - The register write commits on the same edge that raises ack.
  - wbs_dat_o is valid only while ack=1 and is 0 otherwise.
  - After an ack, ack is low for at least one cycle, so the minimum is one transfer per 2 cycles.
  - An unselected address gets no ack.
  - If stb drops before ack, nothing is committed.
- Byte enables: apply per byte to OPA, OPB and STATUS/CTRL writes. CTRL and STATUS use sel[0] only.
- FSM, IDLE:
  - A START write loads shift registers from OPA/OPB[BITS-1:0] and the carry flop from CIN.
  - It clears the bit counter and DONE, and moves to RUN on the ack edge.
  - BUSY and busy_o become 1 in the cycle ack is high.
- FSM, RUN:
  - Each edge computes one full-adder bit, LSB first: sum=a^b^c, c=(a&b)|(c&(a^b)).
  - The sum bit shifts into the result register and the counter increments.
  - After BITS edges: RESULT holds the full sum, COUT holds the final carry, DONE=1, BUSY=0, state returns to IDLE.
  - DONE is therefore visible exactly BITS cycles after the START ack cycle.
- Busy rules:
  - A START write while in RUN is acked and ignored.
  - OPA/OPB/CIN writes while in RUN are acked and update the registers. They do not affect the add in flight, which uses the shift copies.
  - RESULT reads 0 from the START ack until DONE.
- Interrupt: irq_o = DONE & IRQ_EN. A DONE W1C write clears irq_o on the ack edge. If a W1C lands on the same edge DONE is set, the set wins.
- Width: sum wraps modulo 2^BITS and the overflow goes to COUT.
- Reset mid-RUN aborts the add; all registers return to reset values.

Test Plan:
- Reset with no bus traffic -> ack=0, irq_o=0, busy_o=0; reads of 0x00..0x10 all return 0x0.
- BITS=32: OPA=0xFFFF_FFFF, OPB=0x1, CIN=0, START -> busy_o high for 32 cycles; RESULT=0x0; STATUS=0x6 (DONE|COUT) exactly 32 cycles after the START ack.
- OPA=0x1234_5678, OPB=0x0FED_CBA9, CIN=1, IRQ_EN=1 -> RESULT=0x2222_2222, COUT=0, irq_o=1; writing STATUS=0x2 -> irq_o=0 on that ack edge.
- Write OPA=0xAABBCCDD with sel=4'b0010 after OPA=0 -> OPA reads 0x0000_CC00. Read offset 0x18 -> 0, acked. Address BASE_ADDR+0x20 -> no ack.
- During RUN: second START plus write OPB=0xFFFF_FFFF -> both acked; the in-flight result is unchanged; RESULT reflects the original operands.
- wb_rst_ni low at cycle 10 of RUN -> all outputs 0 asynchronously. A new START after release completes normally.

Source files
------------

// File: rtl/wb_serial_adder_slave.sv
// -----------------------------------------------------------------------------
// wb_serial_adder_slave
//
// Wishbone B4 classic slave that gives the management SoC access to a
// bit-serial adder. Two operand registers (OPA/OPB) are loaded over the bus.
// A START write copies them into shift registers, and the adder then produces
// one sum bit per clock, LSB first, for BITS clocks. When the add finishes,
// RESULT holds the sum and COUT holds the carry-out. DONE is raised and can
// drive a level interrupt.
//
// Register window (byte offsets from BASE_ADDR, 32-byte window):
//   0x00 OPA     RW
//   0x04 OPB     RW
//   0x08 CTRL    bit0 START (write-1 pulse, reads 0), bit1 CIN, bit2 IRQ_EN
//   0x0C STATUS  bit0 BUSY (RO), bit1 DONE (W1C), bit2 COUT (RO)
//   0x10 RESULT  RO, reads 0 while an add is in progress
//   0x14..0x1C   read 0, writes ignored
//
// Ports:
//   wb_clk_i   clock for all state
//   wb_rst_ni  asynchronous active-low reset
//   wbs_stb_i  Wishbone strobe
//   wbs_cyc_i  Wishbone cycle
//   wbs_we_i   1 = write, 0 = read
//   wbs_sel_i  byte enables
//   wbs_dat_i  write data
//   wbs_adr_i  byte address
//   wbs_ack_o  one-cycle transfer acknowledge, one cycle after the request
//   wbs_dat_o  read data, valid while ack is high and 0 otherwise
//   irq_o      DONE & IRQ_EN, level
//   busy_o     add in progress
// -----------------------------------------------------------------------------
module wb_serial_adder_slave #(
  parameter int          BITS      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFE0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        busy_o
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_ack;
  logic [31:0]       r_dat;
  logic [BITS-1:0]   r_opa;
  logic [BITS-1:0]   r_opb;
  logic              r_cin;
  logic              r_irq_en;
  logic              r_done;
  logic              r_cout;
  logic              r_busy;
  logic [BITS-1:0]   r_res;
  logic [BITS-1:0]   r_sa;
  logic [BITS-1:0]   r_sb;
  logic              r_c;
  logic [CW-1:0]     r_cnt;

  logic              w_hit;
  logic              w_req;
  logic              w_wr;
  logic              w_rd;
  logic [2:0]        w_off;
  logic [31:0]       w_opa32;
  logic [31:0]       w_opb32;
  logic [31:0]       w_res32;
  logic [31:0]       w_opa_m;
  logic [31:0]       w_opb_m;
  logic [31:0]       w_rdata;
  logic              w_start;
  logic              w_done_clr;
  logic              w_sum;
  logic              w_cnext;
  logic              w_last;
  logic [BITS-1:0]   w_res_next;

  // Per-byte merge of write data into an existing register value.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  assign w_hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  // A new request is only accepted while ack is low, which forces at least
  // one idle cycle between back-to-back transfers.
  assign w_req = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
  assign w_wr  = w_req & wbs_we_i;
  assign w_rd  = w_req & ~wbs_we_i;
  assign w_off = wbs_adr_i[4:2];

  // Zero-extend the BITS-wide registers to the 32-bit bus.
  always_comb begin
    w_opa32 = '0;
    w_opb32 = '0;
    w_res32 = '0;
    w_opa32[BITS-1:0] = r_opa;
    w_opb32[BITS-1:0] = r_opb;
    w_res32[BITS-1:0] = r_res;
  end

  assign w_opa_m = byte_merge(w_opa32, wbs_dat_i, wbs_sel_i);
  assign w_opb_m = byte_merge(w_opb32, wbs_dat_i, wbs_sel_i);

  always_comb begin
    w_rdata = '0;
    case (w_off)
      3'd0: w_rdata = w_opa32;
      3'd1: w_rdata = w_opb32;
      3'd2: w_rdata = {29'd0, r_irq_en, r_cin, 1'b0};
      3'd3: w_rdata = {29'd0, r_cout, r_done, r_busy};
      3'd4: w_rdata = r_busy ? 32'd0 : w_res32;
      default: w_rdata = '0;
    endcase
  end

  // START is honoured only from IDLE; in RUN the write is acked but dropped.
  assign w_start    = w_wr & (w_off == 3'd2) & wbs_sel_i[0] & wbs_dat_i[0] &
                      (r_state == S_IDLE);
  assign w_done_clr = w_wr & (w_off == 3'd3) & wbs_sel_i[0] & wbs_dat_i[1];

  // One full-adder bit per clock on the LSBs of the shift copies.
  assign w_sum      = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_cnext    = (r_sa[0] & r_sb[0]) | (r_c & (r_sa[0] ^ r_sb[0]));
  assign w_last     = (r_cnt == CW'(BITS - 1));
  // Sum bits enter at the MSB so that after BITS shifts the first one is bit 0.
  assign w_res_next = (r_res >> 1) | (BITS'(w_sum) << (BITS - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_cin    <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_res    <= '0;
      r_sa     <= '0;
      r_sb     <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;

      if (w_wr) begin
        case (w_off)
          3'd0: r_opa <= w_opa_m[BITS-1:0];
          3'd1: r_opb <= w_opb_m[BITS-1:0];
          3'd2: begin
            if (wbs_sel_i[0]) begin
              r_cin    <= wbs_dat_i[1];
              r_irq_en <= wbs_dat_i[2];
            end
          end
          default: ;
        endcase
      end

      if (w_done_clr) begin
        r_done <= 1'b0;
      end

      // The sequencer assignments come after the W1C clear, so a DONE set on
      // the same edge as a clear takes priority.
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_sa    <= r_opa;
            r_sb    <= r_opb;
            r_c     <= wbs_dat_i[1];
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_c   <= w_cnext;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout  <= w_cnext;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign busy_o    = r_busy;
  assign irq_o     = r_done & r_irq_en;

endmodule

// File: tb/tb_wb_serial_adder_slave.sv
// -----------------------------------------------------------------------------
// Directed testbench for wb_serial_adder_slave (BITS = 32).
// -----------------------------------------------------------------------------
module tb_wb_serial_adder_slave;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          BITS = 32;

  logic        clk;
  logic        rst_n;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        irq;
  logic        busy;

  int n_cmp;
  int n_err;
  logic g_irq_at_ack;

  wb_serial_adder_slave #(
    .BITS      (BITS),
    .BASE_ADDR (32'h3000_0000),
    .ADDR_MASK (32'hFFFF_FFE0)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .irq_o     (irq),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single bus transfer. Returns at #1 after the edge that raised ack, with
  // the strobe already dropped. Gives up after 4 edges.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdat,
                      output logic acked, output int lat);
    if (ack) begin
      @(posedge clk); #1;
    end
    adr = a; we = w; dat_i = d; sel = s; stb = 1'b1; cyc = 1'b1;
    acked = 1'b0; lat = 0; rdat = '0;
    for (int i = 1; i <= 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        lat = i;
        rdat = dat_o;
        g_irq_at_ack = irq;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s,
                    output logic acked);
    logic [31:0] rd_unused;
    int lat;
    xfer(BASE + off, 1'b1, d, s, rd_unused, acked, lat);
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d, output logic acked);
    int lat;
    xfer(BASE + off, 1'b0, 32'd0, 4'hF, d, acked, lat);
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic a;
    int lat;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ack, irq, busy} !== 3'b000 || dat_o !== 32'd0) begin
      $display("FAIL reset_outputs: ack/irq/busy=%b dat=%h, required 000 and 0", {ack, irq, busy}, dat_o);
      n_err++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      xfer(BASE + 32'(4 * k), 1'b0, 32'd0, 4'hF, d, a, lat);
      n_cmp++;
      if (a !== 1'b1 || lat != 1 || d !== 32'd0) begin
        $display("FAIL reset_read_%0d: ack=%b lat=%0d data=%h, required ack=1 lat=1 data=0", k, a, lat, d);
        n_err++;
      end
    end
  endtask

  task automatic test_carry_wrap;
    logic [31:0] d;
    logic a;
    logic b31;
    logic b32;
    wr(32'h00, 32'hFFFF_FFFF, 4'hF, a);
    wr(32'h04, 32'h0000_0001, 4'hF, a);
    wr(32'h08, 32'h0000_0001, 4'hF, a);
    n_cmp++;
    if (a !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL start_busy: ack=%b busy=%b, required 1 and 1", a, busy);
      n_err++;
    end
    b31 = 1'b0; b32 = 1'b1;
    for (int k = 1; k <= BITS; k++) begin
      @(posedge clk); #1;
      if (k == BITS - 1) b31 = busy;
      if (k == BITS) b32 = busy;
    end
    n_cmp++;
    if (b31 !== 1'b1 || b32 !== 1'b0) begin
      $display("FAIL busy_window: busy@31=%b busy@32=%b, required 1 and 0", b31, b32);
      n_err++;
    end
    rd(32'h10, d, a);
    n_cmp++;
    if (d !== 32'h0000_0000) begin
      $display("FAIL wrap_result: got %h, required 00000000", d);
      n_err++;
    end
    rd(32'h0C, d, a);
    n_cmp++;
    if (d !== 32'h0000_0006) begin
      $display("FAIL wrap_status: got %h, required 00000006", d);
      n_err++;
    end
  endtask

  task automatic test_cin_irq;
    logic [31:0] d;
    logic a;
    logic i31;
    logic i32;
    wr(32'h00, 32'h1234_5678, 4'hF, a);
    wr(32'h04, 32'h0FED_CBA9, 4'hF, a);
    wr(32'h08, 32'h0000_0007, 4'hF, a);
    i31 = 1'b1; i32 = 1'b0;
    for (int k = 1; k <= BITS; k++) begin
      @(posedge clk); #1;
      if (k == BITS - 1) i31 = irq;
      if (k == BITS) i32 = irq;
    end
    n_cmp++;
    if (i31 !== 1'b0 || i32 !== 1'b1) begin
      $display("FAIL irq_timing: irq@31=%b irq@32=%b, required 0 and 1", i31, i32);
      n_err++;
    end
    rd(32'h10, d, a);
    n_cmp++;
    if (d !== 32'h2222_2222) begin
      $display("FAIL cin_result: got %h, required 22222222", d);
      n_err++;
    end
    rd(32'h0C, d, a);
    n_cmp++;
    if (d !== 32'h0000_0002) begin
      $display("FAIL cin_status: got %h, required 00000002", d);
      n_err++;
    end
    rd(32'h08, d, a);
    n_cmp++;
    if (d !== 32'h0000_0006) begin
      $display("FAIL ctrl_readback: got %h, required 00000006", d);
      n_err++;
    end
    wr(32'h0C, 32'h0000_0002, 4'hF, a);
    n_cmp++;
    if (a !== 1'b1 || g_irq_at_ack !== 1'b0) begin
      $display("FAIL irq_clear: ack=%b irq at ack=%b, required 1 and 0", a, g_irq_at_ack);
      n_err++;
    end
    rd(32'h0C, d, a);
    n_cmp++;
    if (d !== 32'h0000_0000) begin
      $display("FAIL status_cleared: got %h, required 00000000", d);
      n_err++;
    end
  endtask

  task automatic test_byte_enable;
    logic [31:0] d;
    logic a;
    int lat;
    wr(32'h00, 32'h0000_0000, 4'hF, a);
    wr(32'h00, 32'hAABB_CCDD, 4'b0010, a);
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b0) begin
      $display("FAIL ack_one_cycle: ack=%b one cycle after ack, required 0", ack);
      n_err++;
    end
    rd(32'h00, d, a);
    n_cmp++;
    if (d !== 32'h0000_CC00) begin
      $display("FAIL byte_enable: got %h, required 0000CC00", d);
      n_err++;
    end
    wr(32'h14, 32'hFFFF_FFFF, 4'hF, a);
    rd(32'h14, d, a);
    n_cmp++;
    if (a !== 1'b1 || d !== 32'd0) begin
      $display("FAIL unused_14: ack=%b data=%h, required 1 and 0", a, d);
      n_err++;
    end
    rd(32'h18, d, a);
    n_cmp++;
    if (a !== 1'b1 || d !== 32'd0) begin
      $display("FAIL unused_18: ack=%b data=%h, required 1 and 0", a, d);
      n_err++;
    end
    xfer(BASE + 32'h20, 1'b0, 32'd0, 4'hF, d, a, lat);
    n_cmp++;
    if (a !== 1'b0) begin
      $display("FAIL out_of_window: ack=%b, required 0", a);
      n_err++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic a1;
    logic a2;
    logic ok;
    wr(32'h00, 32'h0000_0005, 4'hF, a1);
    wr(32'h04, 32'h0000_0003, 4'hF, a1);
    wr(32'h08, 32'h0000_0001, 4'hF, a1);
    wr(32'h08, 32'h0000_0001, 4'hF, a1);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF, a2);
    n_cmp++;
    if (a1 !== 1'b1 || a2 !== 1'b1) begin
      $display("FAIL run_writes_acked: start=%b opb=%b, required 1 and 1", a1, a2);
      n_err++;
    end
    rd(32'h10, d, a1);
    n_cmp++;
    if (busy !== 1'b1 || d !== 32'd0) begin
      $display("FAIL result_hidden: busy=%b data=%h, required 1 and 0", busy, d);
      n_err++;
    end
    wait_idle(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      $display("FAIL run_timeout: busy still %b after 40 cycles, required 0", busy);
      n_err++;
    end
    rd(32'h10, d, a1);
    n_cmp++;
    if (d !== 32'h0000_0008) begin
      $display("FAIL inflight_result: got %h, required 00000008", d);
      n_err++;
    end
    rd(32'h0C, d, a1);
    n_cmp++;
    if (d !== 32'h0000_0002) begin
      $display("FAIL inflight_status: got %h, required 00000002", d);
      n_err++;
    end
    rd(32'h04, d, a1);
    n_cmp++;
    if (d !== 32'hFFFF_FFFF) begin
      $display("FAIL opb_updated: got %h, required FFFFFFFF", d);
      n_err++;
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] d;
    logic a;
    logic ok;
    wr(32'h00, 32'h0000_0001, 4'hF, a);
    wr(32'h04, 32'h0000_0002, 4'hF, a);
    wr(32'h08, 32'h0000_0005, 4'hF, a);
    repeat (10) @(posedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL pre_reset_busy: busy=%b, required 1", busy);
      n_err++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack, irq, busy} !== 3'b000 || dat_o !== 32'd0) begin
      $display("FAIL async_reset: ack/irq/busy=%b dat=%h, required 000 and 0", {ack, irq, busy}, dat_o);
      n_err++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(32'h00, d, a);
    n_cmp++;
    if (d !== 32'd0) begin
      $display("FAIL opa_after_reset: got %h, required 00000000", d);
      n_err++;
    end
    wr(32'h00, 32'h0000_0007, 4'hF, a);
    wr(32'h04, 32'h0000_0009, 4'hF, a);
    wr(32'h08, 32'h0000_0001, 4'hF, a);
    wait_idle(ok);
    rd(32'h10, d, a);
    n_cmp++;
    if (ok !== 1'b1 || d !== 32'h0000_0010) begin
      $display("FAIL restart_result: idle=%b result=%h, required 1 and 00000010", ok, d);
      n_err++;
    end
    rd(32'h0C, d, a);
    n_cmp++;
    if (d !== 32'h0000_0002) begin
      $display("FAIL restart_status: got %h, required 00000002", d);
      n_err++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    g_irq_at_ack = 1'b0;
    rst_n = 1'b0;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0;
    test_reset();
    test_carry_wrap();
    test_cin_irq();
    test_byte_enable();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
